// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin arbitration, one registered execute cycle, and a tagged
// valid/ready response channel. Illegal opcodes (op[3]=1) skip the ALU.
module alu_share_arbiter #(
  parameter int word_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [3:0]           req0_op,
  input  logic [word_size-1:0] req0_a,
  input  logic [word_size-1:0] req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [3:0]           req1_op,
  input  logic [word_size-1:0] req1_a,
  input  logic [word_size-1:0] req1_b,
  output logic                 req1_ready,
  output logic [3:0]           alu_op,
  output logic [word_size-1:0] alu_a,
  output logic [word_size-1:0] alu_b,
  input  logic [word_size-1:0] alu_r,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [word_size-1:0] rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  input  logic                 rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 last_grant;
  logic                 winner;
  logic                 accept;
  logic [3:0]           win_op;
  logic [word_size-1:0] win_a;
  logic [word_size-1:0] win_b;

  // Pick the winner: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
    win_op = winner ? req1_op : req0_op;
    win_a  = winner ? req1_a  : req0_a;
    win_b  = winner ? req1_b  : req0_b;
  end

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode; readies are held low while reset is active.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~winner;
          req1_ready = winner;
          next_state = win_op[3] ? RESP : EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign rsp_valid = (state == RESP);

  // Operand registers feeding the ALU; they only move on accept so the ALU
  // output stays stable through EXEC and RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op <= 4'd0;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (accept) begin
      alu_op <= win_op;
      alu_a  <= win_a;
      alu_b  <= win_b;
    end
  end

  // Response registers: id on accept, result on EXEC or forced error on an illegal op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      rsp_id <= winner;
      if (win_op[3]) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b0;
        rsp_err    <= 1'b1;
      end
    end else if (state == EXEC) begin
      rsp_result <= alu_r;
      rsp_zero   <= alu_zero;
      rsp_err    <= 1'b0;
    end
  end

  // Tie-break pointer moves only when a response is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (state == RESP && rsp_ready) begin
      last_grant <= rsp_id;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed test of the shared-ALU arbiter with a
// small behavioural ALU attached to its alu_* ports.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_r;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic        rsp_ready;

  int errors;
  int checks;

  alu_share_arbiter #(.word_size(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_r      (alu_r),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU (only the opcodes this bench uses).
  always_comb begin
    alu_r = 32'd0;
    case (alu_op)
      4'b0010: alu_r = alu_a + alu_b;
      4'b0011: alu_r = alu_a - alu_b;
      4'b0111: alu_r = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_r = 32'd0;
    endcase
    alu_zero = (alu_r == 32'd0);
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                               input logic [31:0] b0, input logic v1, input logic [3:0] op1,
                               input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0;
    req0_op    = op0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_op    = op1;
    req1_a     = a1;
    req1_b     = b1;
  endtask

  // One solo request with rsp_ready held high, checked cycle by cycle.
  task automatic runSingle(input string tag, input logic id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_zero, input logic exp_err);
    @(negedge clk);
    if (id) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, op, a, b);
    else    applyStimulus(1'b1, op, a, b, 1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    checkOutput({tag, "_ready"}, id ? req1_ready : req0_ready, 64'd1);
    checkOutput({tag, "_other_ready"}, id ? req0_ready : req1_ready, 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    if (!op[3]) begin
      checkOutput({tag, "_exec_valid"}, rsp_valid, 64'd0);
      @(negedge clk);
    end
    checkOutput({tag, "_valid"}, rsp_valid, 64'd1);
    checkOutput({tag, "_id"}, rsp_id, id);
    checkOutput({tag, "_result"}, rsp_result, exp_res);
    checkOutput({tag, "_zero"}, rsp_zero, exp_zero);
    checkOutput({tag, "_err"}, rsp_err, exp_err);
    @(negedge clk);
    checkOutput({tag, "_idle"}, rsp_valid, 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 4'b0010, 32'd1, 32'd1, 1'b1, 4'b0010, 32'd2, 32'd2);
    #1;
    checkOutput("rst_req0_ready", req0_ready, 64'd0);
    checkOutput("rst_req1_ready", req1_ready, 64'd0);
    checkOutput("rst_rsp_valid", rsp_valid, 64'd0);
    checkOutput("rst_alu_op", alu_op, 64'd0);
    checkOutput("rst_rsp_result", rsp_result, 64'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First tie after reset goes to requester 0; valids dropped before the edge.
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 32'd1, 32'd1, 1'b1, 4'b0010, 32'd2, 32'd2);
    #1;
    checkOutput("tie0_req0_ready", req0_ready, 64'd1);
    checkOutput("tie0_req1_ready", req1_ready, 64'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);

    rsp_ready = 1'b1;
    runSingle("add", 1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    runSingle("sub_zero", 1'b1, 4'b0011, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    runSingle("slt", 1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);

    // Contention: both held valid, grants must alternate 0,1,0,1.
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 32'd100, 32'd1, 1'b1, 4'b0011, 32'd50, 32'd8);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("rr%0d_req0_ready", k), req0_ready, (k % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("rr%0d_req1_ready", k), req1_ready, (k % 2 == 1) ? 64'd1 : 64'd0);
      @(negedge clk);
      if (k == 3) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("rr%0d_id", k), rsp_id, (k % 2 == 1) ? 64'd1 : 64'd0);
      checkOutput($sformatf("rr%0d_result", k), rsp_result, (k % 2 == 1) ? 64'd42 : 64'd101);
      @(negedge clk);
    end
    checkOutput("rr_end_idle", rsp_valid, 64'd0);

    // Backpressure: response must freeze and no request may be accepted.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0010, 32'h8000_0000, 32'h8000_0000);
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 32'd7, 32'd7, 1'b1, 4'b0011, 32'd7, 32'd7);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp%0d_valid", c), rsp_valid, 64'd1);
      checkOutput($sformatf("bp%0d_id", c), rsp_id, 64'd1);
      checkOutput($sformatf("bp%0d_result", c), rsp_result, 64'd0);
      checkOutput($sformatf("bp%0d_zero", c), rsp_zero, 64'd1);
      checkOutput($sformatf("bp%0d_readies", c), {req0_ready, req1_ready}, 64'd0);
      checkOutput($sformatf("bp%0d_alu_a", c), alu_a, 64'h8000_0000);
      @(negedge clk);
    end
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_idle", rsp_valid, 64'd0);

    runSingle("illegal", 1'b0, 4'b1010, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);

    // Reset during EXEC: in-flight response is dropped, outputs clear asynchronously.
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0010, 32'd1, 32'd2);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("mid_exec_valid", rsp_valid, 64'd0);
    checkOutput("mid_exec_alu_b", alu_b, 64'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", rsp_valid, 64'd0);
    checkOutput("async_rst_id", rsp_id, 64'd0);
    checkOutput("async_rst_alu_b", alu_b, 64'd0);
    checkOutput("async_rst_alu_op", alu_op, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_no_rsp", rsp_valid, 64'd0);
    runSingle("post_rst", 1'b1, 4'b0010, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
